// File: rtl/hazard_if.sv
// Hazard controller bundle: operand/hazard inputs from the pipeline,
// hold/flush controls back to the pipeline registers.
interface hazard_if;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] RdE;
  logic       load_E;
  logic       PCSrcE;
  logic       md_start_E;
  logic       md_done;
  logic       en_PC;
  logic       en_FD;
  logic       en_DE;
  logic       FlushD;
  logic       FlushE;
  logic       FlushM;
  logic       md_busy;

  modport master (
    output Rs1D, Rs2D, RdE, load_E,
    output PCSrcE, md_start_E, md_done,
    input  en_PC, en_FD, en_DE,
    input  FlushD, FlushE, FlushM, md_busy
  );

  modport slave (
    input  Rs1D, Rs2D, RdE, load_E,
    input  PCSrcE, md_start_E, md_done,
    output en_PC, en_FD, en_DE,
    output FlushD, FlushE, FlushM, md_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / branch / mul-div hazard control for the 5-stage core,
// with stall and flush performance counters.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  hazard_if.slave          hz,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [15:0] TMO_LAST = 16'(MD_TIMEOUT - 1);

  state_t      state;
  state_t      state_nx;
  logic [15:0] tmo_cnt;
  logic [15:0] tmo_nx;
  logic        to_set;
  logic        lu;
  logic        en_pc;
  logic        en_fd;
  logic        en_de;
  logic        fl_d;
  logic        fl_e;
  logic        fl_m;
  logic        busy;

  assign lu = hz.load_E & (hz.RdE != 5'd0) &
              ((hz.RdE == hz.Rs1D) | (hz.RdE == hz.Rs2D));

  always_comb begin
    state_nx = state;
    tmo_nx   = tmo_cnt;
    to_set   = 1'b0;
    en_pc    = 1'b1;
    en_fd    = 1'b1;
    en_de    = 1'b1;
    fl_d     = 1'b0;
    fl_e     = 1'b0;
    fl_m     = 1'b0;
    busy     = 1'b0;
    unique case (state)
      RUN: begin
        if (hz.md_start_E & ~hz.md_done) begin
          en_pc    = 1'b0;
          en_fd    = 1'b0;
          en_de    = 1'b0;
          fl_m     = 1'b1;
          state_nx = MD_BUSY;
          tmo_nx   = 16'd1;
        end else if (hz.PCSrcE) begin
          fl_d = 1'b1;
          fl_e = 1'b1;
        end else if (lu) begin
          en_pc = 1'b0;
          en_fd = 1'b0;
          fl_e  = 1'b1;
        end
      end
      MD_BUSY: begin
        // Release is combinational so the result-producing cycle advances.
        if (hz.md_done) begin
          state_nx = RUN;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nx = RUN;
          to_set   = 1'b1;
        end else begin
          en_pc  = 1'b0;
          en_fd  = 1'b0;
          en_de  = 1'b0;
          fl_m   = 1'b1;
          busy   = 1'b1;
          tmo_nx = tmo_cnt + 16'd1;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= RUN;
      tmo_cnt      <= '0;
      md_timeout   <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state   <= state_nx;
      tmo_cnt <= tmo_nx;
      if (to_set)
        md_timeout <= 1'b1;
      if (!en_pc)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (fl_d | fl_e)
        flush_events <= flush_events + CNT_W'(1);
    end
  end

  assign hz.en_PC   = en_pc;
  assign hz.en_FD   = en_fd;
  assign hz.en_DE   = en_de;
  assign hz.FlushD  = fl_d;
  assign hz.FlushE  = fl_e;
  assign hz.FlushM  = fl_m;
  assign hz.md_busy = busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected controls queued per step,
// counters and sticky timeout tracked from the expected control vectors.
module tb_hazard_ctrl;

  // {en_PC, en_FD, en_DE, FlushD, FlushE, FlushM, md_busy}
  localparam logic [6:0] NRM = 7'b111_000_0;
  localparam logic [6:0] LU  = 7'b001_010_0;
  localparam logic [6:0] BR  = 7'b111_110_0;
  localparam logic [6:0] MDS = 7'b000_001_0;
  localparam logic [6:0] BSY = 7'b000_001_1;

  typedef struct {
    string      tag;
    logic [6:0] outs;
  } exp_t;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        md_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;
  logic        m_to = 1'b0;
  exp_t        sbq[$];

  hazard_if hz ();

  hazard_ctrl #(
    .MD_TIMEOUT(8),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .hz(hz.slave),
    .md_timeout(md_timeout),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {hz.en_PC, hz.en_FD, hz.en_DE,
            hz.FlushD, hz.FlushE, hz.FlushM, hz.md_busy};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic ld,
                       input logic br, input logic ms,
                       input logic md);
    hz.Rs1D       = rs1;
    hz.Rs2D       = rs2;
    hz.RdE        = rd;
    hz.load_E     = ld;
    hz.PCSrcE     = br;
    hz.md_start_E = ms;
    hz.md_done    = md;
  endtask

  task automatic step(input string tag,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic ld,
                      input logic br, input logic ms,
                      input logic md, input logic [6:0] exp,
                      input logic to_after);
    exp_t e;
    @(negedge clk);
    assert (!(ms && br)) else
      $error("illegal md_start_E with PCSrcE in %s", tag);
    drive(rs1, rs2, rd, ld, br, ms, md);
    e.tag  = tag;
    e.outs = exp;
    sbq.push_back(e);
    #1;
    e = sbq.pop_front();
    checks++;
    assert (obs() === e.outs) else begin
      failures++;
      $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs(), e.outs);
    end
    if (!exp[6])
      m_stall++;
    if (exp[3] | exp[2])
      m_flush++;
    m_to = to_after;
    @(posedge clk);
    #1;
    chk({tag, "_stall"}, 64'(stall_cycles), 64'(m_stall));
    chk({tag, "_flush"}, 64'(flush_events), 64'(m_flush));
    chk({tag, "_tmo"}, 64'(md_timeout), 64'(m_to));
  endtask

  initial begin
    n_rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_ctl", 64'(obs()), 64'(NRM));
    chk("rst_stall", 64'(stall_cycles), 64'd0);
    chk("rst_flush", 64'(flush_events), 64'd0);
    chk("rst_tmo", 64'(md_timeout), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;

    step("idle", 0, 0, 0, 0, 0, 0, 0, NRM, 0);
    step("lu_rs2", 1, 5, 5, 1, 0, 0, 0, LU, 0);
    step("lu_after", 1, 5, 0, 0, 0, 0, 0, NRM, 0);
    step("lu_rs1", 5, 2, 5, 1, 0, 0, 0, LU, 0);
    step("lu_rd0", 0, 3, 0, 1, 0, 0, 0, NRM, 0);
    step("lu_noload", 7, 7, 7, 0, 0, 0, 0, NRM, 0);
    step("br_lu", 5, 0, 5, 1, 1, 0, 0, BR, 0);
    step("br_only", 1, 2, 3, 0, 1, 0, 0, BR, 0);

    step("md_start", 0, 0, 0, 0, 0, 1, 0, MDS, 0);
    step("md_b1", 5, 5, 5, 1, 1, 0, 0, BSY, 0);
    step("md_b2", 0, 0, 0, 0, 0, 1, 0, BSY, 0);
    step("md_b3", 0, 0, 0, 0, 0, 0, 0, BSY, 0);
    step("md_done", 0, 0, 0, 0, 0, 0, 1, NRM, 0);
    step("md_post", 0, 0, 0, 0, 0, 0, 0, NRM, 0);

    step("md_1cyc", 0, 0, 0, 0, 0, 1, 1, NRM, 0);
    step("md_1cyc_nx", 0, 0, 0, 0, 0, 0, 0, NRM, 0);
    step("md_1cyc_lu", 5, 0, 5, 1, 0, 1, 1, LU, 0);

    step("to_start", 0, 0, 0, 0, 0, 1, 0, MDS, 0);
    for (int i = 1; i < 7; i++)
      step($sformatf("to_b%0d", i), 0, 0, 0, 0, 0, 0, 0, BSY, 0);
    step("to_rel", 0, 0, 0, 0, 0, 0, 0, NRM, 1);
    step("to_sticky1", 5, 0, 5, 1, 0, 0, 0, LU, 1);
    step("to_sticky2", 0, 0, 0, 0, 0, 0, 0, NRM, 1);

    step("rs_start", 0, 0, 0, 0, 0, 1, 0, MDS, 1);
    step("rs_b1", 0, 0, 0, 0, 0, 0, 0, BSY, 1);
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    chk("rs_ctl", 64'(obs()), 64'(NRM));
    chk("rs_stall", 64'(stall_cycles), 64'd0);
    chk("rs_flush", 64'(flush_events), 64'd0);
    chk("rs_tmo", 64'(md_timeout), 64'd0);
    @(negedge clk);
    n_rst   = 1'b1;
    m_stall = '0;
    m_flush = '0;
    m_to    = 1'b0;

    step("rs_md_start", 0, 0, 0, 0, 0, 1, 0, MDS, 0);
    step("rs_md_b1", 0, 0, 0, 0, 0, 0, 0, BSY, 0);
    step("rs_md_done", 0, 0, 0, 0, 0, 0, 1, NRM, 0);
    step("rs_br", 0, 0, 0, 0, 1, 0, 0, BR, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
